// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo: width functions, wrapping pointer increment
// and the registered status-flag bundle.
package sync_fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Depth need not be a power of two, so the wrap is an explicit compare.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a sync_fifo and its user.
interface sync_fifo_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 45
);
   localparam int CNT_W = cnt_width(DEPTH);

   logic                  flush;
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CNT_W-1:0]      count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, w_en, data_in, r_en,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, w_en, data_in, r_en,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH simple dual-port storage: one write port, one registered
// read port. Contents are deliberately not reset.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 45,
   parameter int ADDR_W     = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags and
// sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 45,
   parameter int AF_LEVEL   = DEPTH - 4,
   parameter int AE_LEVEL   = 4
) (
   input logic        clk,
   input logic        arstn,
   sync_fifo_if.slave fifo
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

   logic [PTR_W-1:0]      w_ptr_q, w_ptr_nxt;
   logic [PTR_W-1:0]      r_ptr_q, r_ptr_nxt;
   logic [CNT_W-1:0]      count_q, count_nxt;
   fifo_flags_t           flags_q, flags_nxt;
   logic                  overflow_q, overflow_nxt;
   logic                  underflow_q, underflow_nxt;
   logic                  out_valid_q, out_valid_nxt;
   logic                  empty_nxt;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_re;
   logic [DATA_WIDTH-1:0] ram_q;

   // Requests are judged against the registered flags; flush overrides both.
   always_comb begin
      wr_acc        = !fifo.flush && fifo.w_en && !flags_q.full;
      rd_acc        = !fifo.flush && fifo.r_en && !flags_q.empty;
      overflow_nxt  = overflow_q;
      underflow_nxt = underflow_q;
      if (fifo.flush) begin
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end else begin
         if (fifo.w_en && flags_q.full) begin
            overflow_nxt = 1'b1;
         end
         if (fifo.r_en && flags_q.empty) begin
            underflow_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      count_nxt = count_q;
      if (fifo.flush) begin
         count_nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         count_nxt = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count_q - 1'b1;
      end
   end

   always_comb begin
      w_ptr_nxt = w_ptr_q;
      r_ptr_nxt = r_ptr_q;
      if (fifo.flush) begin
         w_ptr_nxt = '0;
         r_ptr_nxt = '0;
      end else begin
         if (wr_acc) begin
            w_ptr_nxt = PTR_W'(next_ptr(32'(w_ptr_q), DEPTH));
         end
         if (ram_re) begin
            r_ptr_nxt = PTR_W'(next_ptr(32'(r_ptr_q), DEPTH));
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // The RAM read register doubles as the head-word register. ram_cnt tracks
   // words still in the array; empty means the head register holds nothing.
   logic [CNT_W-1:0] ram_cnt_q, ram_cnt_nxt;

   always_comb begin
      ram_re      = !fifo.flush && (ram_cnt_q != '0) && (!out_valid_q || rd_acc);
      ram_cnt_nxt = ram_cnt_q;
      if (fifo.flush) begin
         ram_cnt_nxt = '0;
      end else if (wr_acc && !ram_re) begin
         ram_cnt_nxt = ram_cnt_q + 1'b1;
      end else if (ram_re && !wr_acc) begin
         ram_cnt_nxt = ram_cnt_q - 1'b1;
      end

      out_valid_nxt = out_valid_q;
      if (fifo.flush) begin
         out_valid_nxt = 1'b0;
      end else if (ram_re) begin
         out_valid_nxt = 1'b1;
      end else if (rd_acc) begin
         out_valid_nxt = 1'b0;
      end
      empty_nxt = !out_valid_nxt;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         ram_cnt_q <= '0;
      end else begin
         ram_cnt_q <= ram_cnt_nxt;
      end
   end
`else
   // Standard mode: out_valid only masks data_out to zero until the first read
   // after reset or flush, since the RAM read register itself is never reset.
   always_comb begin
      ram_re        = rd_acc;
      out_valid_nxt = fifo.flush ? 1'b0 : (out_valid_q || rd_acc);
      empty_nxt     = (count_nxt == '0);
   end
`endif

   always_comb begin
      flags_nxt.full         = (count_nxt == CNT_FULL);
      flags_nxt.empty        = empty_nxt;
      flags_nxt.almost_full  = (count_nxt >= CNT_AF);
      flags_nxt.almost_empty = (count_nxt <= CNT_AE);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         count_q     <= '0;
         flags_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_nxt;
         r_ptr_q     <= r_ptr_nxt;
         count_q     <= count_nxt;
         flags_q     <= flags_nxt;
         overflow_q  <= overflow_nxt;
         underflow_q <= underflow_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (w_ptr_q),
      .wdata (fifo.data_in),
      .re    (ram_re),
      .raddr (r_ptr_q),
      .rdata (ram_q)
   );

   assign fifo.data_out     = out_valid_q ? ram_q : '0;
   assign fifo.full         = flags_q.full;
   assign fifo.empty        = flags_q.empty;
   assign fifo.almost_full  = flags_q.almost_full;
   assign fifo.almost_empty = flags_q.almost_empty;
   assign fifo.count        = count_q;
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo (DEPTH=45) against a queue-based
// reference model; honours SYNC_FIFO_FWFT_EN when the design is built with it.
module tb_sync_fifo;

   localparam int DW       = 8;
   localparam int DEPTH    = 45;
   localparam int AF_LEVEL = DEPTH - 4;
   localparam int AE_LEVEL = 4;

   logic clk;
   logic arstn;

   int check_count = 0;
   int pass_count  = 0;
   bit check_en    = 0;

   // Reference state: words held in order, plus the visible head word in FWFT.
   logic [DW-1:0] store[$];
   logic [DW-1:0] head;
   bit            head_valid;
   logic [DW-1:0] m_dout;
   bit            m_ovf;
   bit            m_udf;

   sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .fifo  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_count();
`ifdef SYNC_FIFO_FWFT_EN
      return store.size() + int'(head_valid);
`else
      return store.size();
`endif
   endfunction

   function automatic bit m_empty();
`ifdef SYNC_FIFO_FWFT_EN
      return !head_valid;
`else
      return store.size() == 0;
`endif
   endfunction

   // Reference model: one step per rising edge, reset asynchronously.
   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         store.delete();
         head_valid = 0;
         head       = '0;
         m_dout     = '0;
         m_ovf      = 0;
         m_udf      = 0;
      end else if (bus.flush) begin
         store.delete();
         head_valid = 0;
         m_dout     = '0;
         m_ovf      = 0;
         m_udf      = 0;
      end else begin
         bit full_m, empty_m, wacc, racc;
         full_m  = (m_count() == DEPTH);
         empty_m = m_empty();
         wacc    = bus.w_en && !full_m;
         racc    = bus.r_en && !empty_m;
         if (bus.w_en && full_m) m_ovf = 1;
         if (bus.r_en && empty_m) m_udf = 1;
`ifdef SYNC_FIFO_FWFT_EN
         if (racc) head_valid = 0;
         if (!head_valid && store.size() > 0) begin
            head       = store.pop_front();
            head_valid = 1;
         end
         if (wacc) store.push_back(bus.data_in);
         m_dout = head_valid ? head : '0;
`else
         if (racc) m_dout = store.pop_front();
         if (wacc) store.push_back(bus.data_in);
`endif
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      check_count++;
      if (act == exp) pass_count++;
      else $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                    name, $time, act, act, exp, exp);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      if (arstn && check_en) begin
         checkOutput("count",        int'(bus.count),        m_count());
         checkOutput("full",         int'(bus.full),         int'(m_count() == DEPTH));
         checkOutput("empty",        int'(bus.empty),        int'(m_empty()));
         checkOutput("almost_full",  int'(bus.almost_full),  int'(m_count() >= AF_LEVEL));
         checkOutput("almost_empty", int'(bus.almost_empty), int'(m_count() <= AE_LEVEL));
         checkOutput("overflow",     int'(bus.overflow),     int'(m_ovf));
         checkOutput("underflow",    int'(bus.underflow),    int'(m_udf));
         checkOutput("data_out",     int'(bus.data_out),     int'(m_dout));
      end
   end

   // Drive one cycle of inputs at the falling edge; returns just after the rising edge.
   task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d, input logic f);
      @(negedge clk);
      bus.w_en    = w;
      bus.r_en    = r;
      bus.data_in = d;
      bus.flush   = f;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_count"},        int'(bus.count),        0);
      checkOutput({tag, "_empty"},        int'(bus.empty),        1);
      checkOutput({tag, "_almost_empty"}, int'(bus.almost_empty), 1);
      checkOutput({tag, "_full"},         int'(bus.full),         0);
      checkOutput({tag, "_almost_full"},  int'(bus.almost_full),  0);
      checkOutput({tag, "_overflow"},     int'(bus.overflow),     0);
      checkOutput({tag, "_underflow"},    int'(bus.underflow),    0);
      checkOutput({tag, "_data_out"},     int'(bus.data_out),     0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      arstn       = 1'b0;
      bus.w_en    = 1'b0;
      bus.r_en    = 1'b0;
      bus.flush   = 1'b0;
      bus.data_in = '0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      arstn    = 1'b1;
      check_en = 1;

      // Fill to DEPTH, watching almost_full and full arrive on the right edge.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 0, DW'(i), 0);
         if (i == AF_LEVEL - 2) checkOutput("af_before_level", int'(bus.almost_full), 0);
         if (i == AF_LEVEL - 1) checkOutput("af_at_level", int'(bus.almost_full), 1);
      end
      checkOutput("fill_full",  int'(bus.full),  1);
      checkOutput("fill_count", int'(bus.count), 45);
      applyStimulus(1, 0, 8'hEE, 0);
      checkOutput("overflow_set",     int'(bus.overflow), 1);
      checkOutput("overflow_count",   int'(bus.count),    45);

      // Drain in order, then one extra read.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 1, '0, 0);
`ifndef SYNC_FIFO_FWFT_EN
         if (i == 0) checkOutput("first_read_data", int'(bus.data_out), 8'h00);
`endif
      end
      checkOutput("drain_empty", int'(bus.empty), 1);
      applyStimulus(0, 1, '0, 0);
      checkOutput("underflow_set", int'(bus.underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
      checkOutput("underflow_hold_data", int'(bus.data_out), 8'h2C);
`endif
      applyStimulus(0, 0, '0, 1);

      // Wrap pointers past DEPTH-1 several times.
      for (int round = 0; round < 4; round++) begin
         for (int i = 0; i < 30; i++) applyStimulus(1, 0, DW'($urandom), 0);
         for (int i = 0; i < 30; i++) applyStimulus(0, 1, '0, 0);
         checkOutput("wrap_round_count", int'(bus.count), 0);
      end

      // Sustained simultaneous traffic, then simultaneous at full.
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, DW'($urandom), 0);
      for (int i = 0; i < 100; i++) applyStimulus(1, 1, DW'($urandom), 0);
      checkOutput("simul_count", int'(bus.count), 20);
      for (int i = 0; i < 25; i++) applyStimulus(1, 0, DW'($urandom), 0);
      applyStimulus(1, 1, 8'h77, 0);
      checkOutput("full_simul_count",    int'(bus.count),    44);
      checkOutput("full_simul_overflow", int'(bus.overflow), 1);

      // Flush with 12 words held and overflow pending.
      for (int i = 0; i < 32; i++) applyStimulus(0, 1, '0, 0);
      checkOutput("preflush_count", int'(bus.count), 12);
      applyStimulus(1, 1, 8'h55, 1);
      checkResetValues("flush");
`ifdef SYNC_FIFO_FWFT_EN
      applyStimulus(1, 0, 8'hA5, 0);
      checkOutput("fwft_fill_edge1_empty", int'(bus.empty), 1);
      applyStimulus(0, 0, '0, 0);
      checkOutput("fwft_fill_edge2_empty", int'(bus.empty),    0);
      checkOutput("fwft_fill_edge2_data",  int'(bus.data_out), 8'hA5);
`endif

      // Randomised traffic with occasional flushes.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(logic'($urandom_range(0, 99) < 55),
                       logic'($urandom_range(0, 99) < 50),
                       DW'($urandom),
                       logic'($urandom_range(0, 63) == 0));
      end

      // Asynchronous reset in the middle of traffic.
      applyStimulus(0, 0, '0, 1);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, DW'($urandom), 0);
      checkOutput("premid_reset_count", int'(bus.count), 10);
      @(negedge clk);
      bus.w_en = 1'b0;
      #2 arstn = 1'b0;
      #1;
      checkResetValues("mid_reset");
      @(negedge clk);
      arstn = 1'b1;
      applyStimulus(0, 0, '0, 0);
      checkOutput("post_reset_count", int'(bus.count), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags. It is the single-clock successor of the team's FIFO storage, for buffering within one clock domain (e.g. ahead of the async FIFO write side). Read mode is standard (registered read, 1-cycle latency) or first-word-fall-through, selected at compile time.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- DEPTH, 45, number of entries; any integer >=2
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL
- clk  in  1  single clock for all logic
- arstn  in  1  reset; one clock, reset asynchronous and active-low
- flush  in  1  synchronous clear, highest priority
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  $clog2(DEPTH+1)  words held
- overflow, underflow  out  1  sticky error flags

## Operation
- Reset (arstn=0, asynchronous): w_ptr=r_ptr=0, count=0, data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. Memory contents not reset.
- Write accepted iff w_en && !full; read accepted iff r_en && !empty. Flags sampled are the registered flags of the current cycle.
- Rejected write (w_en && full) sets overflow; rejected read (r_en && empty) sets underflow; both stay set until flush or reset. Rejected requests change no other state.
- Pointers range 0..DEPTH-1; increment from DEPTH-1 wraps to 0 (explicit compare, not modulo 2^n).
- count: +1 write only, -1 read only, unchanged for both or neither. count never exceeds DEPTH nor underflows.
- Simultaneous write and read when neither boundary blocks: both accepted, count unchanged. When full, write rejected even if a read is accepted the same cycle; when empty, read rejected even if a write is accepted.
- flush=1: pointers, count, data_out, error flags cleared as at reset; w_en/r_en ignored that cycle; memory contents untouched.
- Flags are registered and derived from next-state count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).

## Timing
- All outputs change only on rising clk (except async reset).
- Write accepted at edge N: count, empty, full, almost flags reflect it after edge N.
- Standard mode: read accepted at edge N -> data_out holds mem[r_ptr] after edge N (1-cycle latency); data_out holds its value when no read accepted.
- Write-to-readable: word written at edge N is readable by r_en sampled at edge N+1.
- Back-to-back: one write and one read per cycle sustained indefinitely with 0 < count < DEPTH.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Undefined: standard mode as above.
- Defined: first-word-fall-through. An output register holds the head word; data_out is valid whenever empty=0; r_en accepted pops it and the next word (if any) appears after the same edge. Empty-FIFO write at edge N -> empty=0 and data_out=that word after edge N+1 (2-edge fill latency). count includes the output-register word; full still at count==DEPTH. flush/reset invalidate the output register.

## Structure
- Package sync_fifo_pkg: localparam-style function for pointer width ($clog2(DEPTH)) and count width ($clog2(DEPTH+1)), pointer-increment-with-wrap function, shared by the top level.
- Sub-module fifo_ram: DEPTH x DATA_WIDTH simple dual-port array, one write port, one registered read port, no reset. sync_fifo contains pointer/count/flag control and (FWFT) output register.

## Test plan
- Reset mid-traffic: arstn low with count=10 -> all outputs at reset values immediately; count=0, empty=1.
- Fill DEPTH=45: 45 writes 0x00..0x2C -> full=1 after 45th edge, almost_full=1 after 41st; 46th write rejected, overflow=1, count stays 45.
- Drain: 45 reads -> data_out 0x00..0x2C in order, 1-cycle latency (standard); empty=1 after last; extra read sets underflow, data_out holds 0x2C.
- Wrap: 30 writes, 30 reads, repeated 4 times -> pointers wrap at 44->0, no data corruption, count returns to 0 each round.
- Simultaneous: count=20, w_en=r_en=1 for 100 cycles -> count stays 20, data ordered; at full with both asserted -> only read accepted, count 44.
- Flush with count=12 and overflow=1 -> after edge count=0, empty=1, overflow=0, data_out=0; FWFT build: first write after flush shows on data_out 2 edges later.
